serial_rom_reader: RTL

- Parametrised ROM that serialises one stored word per read, one bit per clock.
- Successor to the 4x4 serial-address ROM. Adds generic width and depth, selectable bit order, and a start/busy/done handshake with per-bit valid and last-bit flags.
- Adds an optional auto-increment burst mode for back-to-back words.
- Sits between address-generating control logic and any bit-serial consumer (LED driver, shift chain, UART-like framer) on the internal oscillator domain.

---
 rtl/serial_rom_reader.sv | 121 ++++++++++++
 1 files changed

// File: rtl/serial_rom_reader.sv
// Bit-serial ROM reader: one stored word per read, one bit per clock,
// with start/busy/done handshake and optional auto-increment bursts.
module serial_rom_reader #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int MSB_FIRST = 0,
    parameter int AUTO_INC  = 0
) (
    input  logic          int_osc,
    input  logic          rst,
    input  logic [AW-1:0] ADDR,
    input  logic          CS,
    input  logic          start,
    output logic          OUT,
    output logic          OUT_VALID,
    output logic          LAST,
    output logic          busy,
    output logic          done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state_q;
    logic [WIDTH-1:0] sh_q;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   addr_q;
    logic [AW-1:0]   addr_inc;
    logic [WIDTH-1:0] word_new;
    logic [WIDTH-1:0] word_inc;

    // Contents are mem[i] = i mod 2^WIDTH; holes past DEPTH read as zero.
    function automatic logic [WIDTH-1:0] rom_word(input logic [AW-1:0] a);
        logic [31:0] v;
        v = 32'(a);
        if (v >= 32'(DEPTH))
            return '0;
        return v[WIDTH-1:0];
    endfunction

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_on(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
    endfunction

    assign addr_inc = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
    assign word_new = rom_word(ADDR);
    assign word_inc = rom_word(addr_inc);

    always_ff @(posedge int_osc or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            OUT       <= 1'b0;
            OUT_VALID <= 1'b0;
            LAST      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (CS && start) begin
                        addr_q    <= ADDR;
                        OUT       <= first_bit(word_new);
                        sh_q      <= shift_on(word_new);
                        OUT_VALID <= 1'b1;
                        LAST      <= (WIDTH == 1);
                        cnt_q     <= CW'(1);
                        busy      <= 1'b1;
                        state_q   <= SHIFT;
                    end else begin
                        OUT       <= 1'b0;
                        OUT_VALID <= 1'b0;
                        LAST      <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (!CS) begin
                        OUT       <= 1'b0;
                        OUT_VALID <= 1'b0;
                        LAST      <= 1'b0;
                        busy      <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= IDLE;
                    end else if (cnt_q == CW'(WIDTH)) begin
                        // Word boundary: chain the next word or finish.
                        if (AUTO_INC != 0 && start) begin
                            addr_q <= addr_inc;
                            OUT    <= first_bit(word_inc);
                            sh_q   <= shift_on(word_inc);
                            LAST   <= (WIDTH == 1);
                            cnt_q  <= CW'(1);
                        end else begin
                            OUT       <= 1'b0;
                            OUT_VALID <= 1'b0;
                            LAST      <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            cnt_q     <= '0;
                            state_q   <= IDLE;
                        end
                    end else begin
                        OUT   <= first_bit(sh_q);
                        sh_q  <= shift_on(sh_q);
                        LAST  <= (cnt_q == CW'(WIDTH - 1));
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule
